data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Multi-cycle data memory for the MIPS datapath. Sits in the MEM stage directly upstream of the write-back select: accepts a load/store request from the control unit and ALU address, performs it after a fixed access latency with sized, sign- or zero-extended loads, and presents the 32-bit ReadData consumed by write-back. Emits ready/busy so control can stall the PC until completion.

Parameters:
DEPTH_LOG2, 10, number of 32-bit words = 2^DEPTH_LOG2; upper address bits ignored (wrap).
LATENCY, 2, cycles spent in WAIT before completion (1..15).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
MemRead  in  1  load request, held until MemReady
MemWrite  in  1  store request, held until MemReady
MemSize  in  2  00 byte, 01 half, 10 word, 11 illegal
MemUnsigned  in  1  1 = zero-extend sub-word load, 0 = sign-extend
Address  in  32  byte address from ALUResult
WriteData  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
ReadData  out  32  last completed load result, extended
MemBusy  out  1  request accepted and not yet complete (stall PC)
MemReady  out  1  one-cycle completion pulse
MemError  out  1  one-cycle pulse: misaligned, illegal size, or Read&Write both set

Behaviour:
- Reset (rst_n=0 at edge): FSM->IDLE, counter=0, ReadData=0, MemBusy=0, MemReady=0, MemError=0. Memory array NOT cleared. Reset mid-operation aborts request; a store not yet committed is never written.
- FSM states IDLE, WAIT, DONE.
- IDLE: if MemRead^MemWrite and request legal -> latch Address, MemSize, MemUnsigned, WriteData, op; counter=LATENCY-1; go WAIT. MemBusy=1 from the next cycle.
- IDLE, illegal request (MemRead&MemWrite, MemSize=11, half with Address[0]=1, word with Address[1:0]!=0): MemError=1 for one cycle, stay IDLE, no access, ReadData unchanged. Control drops request after error; if held, error re-pulses every other cycle (IDLE->ERRGAP via MemError cycle: error asserted one cycle, then one idle cycle before re-evaluation).
- WAIT: decrement counter; when counter=0 go DONE. Inputs ignored (latched copy used).
- DONE (one cycle): MemReady=1, MemBusy=0. Store: byte-enabled write of word index Address[DEPTH_LOG2+1:2] commits at this edge. Load: ReadData updated at this edge. Next state IDLE; a request still asserted in the IDLE cycle after DONE is treated as new, so control must drop it on MemReady.
- Total request-to-MemReady latency = LATENCY+1 cycles from the IDLE acceptance edge.
- Byte order little-endian: byte k of word = bits [8k+7:8k]; half at Address[1] selects [15:0] or [31:16].
- Store byte enables: byte -> 1<<Address[1:0]; half -> 0011 or 1100; word -> 1111. Unenabled bytes preserved.
- Load extension: byte/half sign bit = MSB of selected field when MemUnsigned=0; word ignores MemUnsigned.
- ReadData holds between loads; unaffected by stores and errors.
- Address bits above DEPTH_LOG2+1 ignored: address 2^(DEPTH_LOG2+2) aliases 0.

Decomposition:
- Shared package: MemSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), FSM state encodings.
- One sub-module: dmem_lane_align — combinational byte-enable generation, store data lane replication, load field select and extension.

Test Plan:
- Reset then idle: rst_n=0 two cycles -> ReadData=0, MemBusy=0, MemReady=0, MemError=0.
- sw 0xDEADBEEF @0x10, then lw @0x10, LATENCY=2 -> MemReady 3 cycles after each acceptance, ReadData=0xDEADBEEF, MemBusy high exactly 2 cycles each.
- Sub-word: after above, sb 0x7F @0x12 then lb @0x12 -> 0x0000007F; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x10 -> 0xFFFFBEEF; lw @0x10 -> 0xDE7FBEEF.
- Errors: lw @0x11, sh @0x13, MemSize=11, MemRead=MemWrite=1 -> each single MemError pulse, no MemBusy, memory and ReadData unchanged.
- Reset mid-store: sw 0x12345678 @0x20, rst_n=0 during WAIT -> subsequent lw @0x20 returns prior contents.
- Wrap: DEPTH_LOG2=10, sw 0xA5A5A5A5 @0x1000 then lw @0x0 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, controller states
// and the request legality rule.
package data_memory_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_DONE   = 2'b10,
        ST_ERRGAP = 2'b11
    } dmem_state_t;

    // Size must be defined and the address naturally aligned for that size.
    function automatic logic is_legal_req(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_lane_align.sv
// Little-endian lane steering: store byte enables and data replication, load field
// select with sign or zero extension.
module dmem_lane_align
    import data_memory_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_fld_s;
    logic [15:0] half_fld_s;

    // Replicating store data across lanes lets the byte enables alone pick the target.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        byte_fld_s = rword[{addr_lo, 3'b000} +: 8];
        half_fld_s = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{~is_unsigned & byte_fld_s[7]}}, byte_fld_s};
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{~is_unsigned & half_fld_s[15]}}, half_fld_s};
            end
            SIZE_WORD: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: begin
                byte_en    = 4'b0000;
                wdata_lane = 32'h0000_0000;
                rdata_ext  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory for the MEM stage: fixed-latency sized loads/stores with
// busy/ready handshake and a single-cycle error pulse for illegal requests.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemBusy,
    output logic        MemReady,
    output logic        MemError
);

    dmem_state_t             state_r, state_nxt_s;
    logic [3:0]              cnt_r, cnt_nxt_s;
    logic                    accept_s, err_s, commit_s;
    logic                    op_write_r, uns_r;
    logic [1:0]              size_r;
    logic [DEPTH_LOG2+1:0]   addr_r;
    logic [31:0]             wdata_r, rdata_r;
    logic                    busy_r, ready_r, error_r;
    logic [31:0]             mem_r [0:(1 << DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]   word_idx_s;
    logic [31:0]             rword_s, wdata_lane_s, rdata_ext_s;
    logic [3:0]              byte_en_s;
    logic                    unused_addr_s;

    assign unused_addr_s = ^Address[31:DEPTH_LOG2+2];
    assign word_idx_s    = addr_r[DEPTH_LOG2+1:2];
    assign rword_s       = mem_r[word_idx_s];

    dmem_lane_align u_lane (
        .size        (size_r),
        .addr_lo     (addr_r[1:0]),
        .is_unsigned (uns_r),
        .wdata       (wdata_r),
        .rword       (rword_s),
        .byte_en     (byte_en_s),
        .wdata_lane  (wdata_lane_s),
        .rdata_ext   (rdata_ext_s)
    );

    // Next-state and per-cycle strobes; inputs are only examined in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        err_s       = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((MemRead ^ MemWrite) && is_legal_req(MemSize, Address[1:0])) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = 4'(LATENCY - 1);
                    state_nxt_s = ST_WAIT;
                end else if (MemRead | MemWrite) begin
                    err_s       = 1'b1;
                    state_nxt_s = ST_ERRGAP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                commit_s    = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            ST_ERRGAP: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_WAIT);
            ready_r <= commit_s;
            error_r <= err_s;
        end
    end

    // Request capture on acceptance and load result update on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_write_r <= 1'b0;
            uns_r      <= 1'b0;
            size_r     <= SIZE_BYTE;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                op_write_r <= MemWrite;
                uns_r      <= MemUnsigned;
                size_r     <= MemSize;
                addr_r     <= Address[DEPTH_LOG2+1:0];
                wdata_r    <= WriteData;
            end
            if (commit_s && !op_write_r) begin
                rdata_r <= rdata_ext_s;
            end
        end
    end

    // Store commit; gated by reset so an aborted store never reaches the array.
    always_ff @(posedge clk) begin
        if (rst_n && commit_s && op_write_r) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en_s[k]) begin
                    mem_r[word_idx_s][8*k +: 8] <= wdata_lane_s[8*k +: 8];
                end
            end
        end
    end

    assign ReadData = rdata_r;
    assign MemBusy  = busy_r;
    assign MemReady = ready_r;
    assign MemError = error_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed plus randomized bench for data_memory_ctrl against a byte-array style
// reference memory.
module tb_data_memory_ctrl;

    localparam int DEPTH = 10;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, MemUnsigned = 1'b0;
    logic [1:0]  MemSize = 2'b00;
    logic [31:0] Address = 32'h0, WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        MemBusy, MemReady, MemError;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_mem [0:(1 << DEPTH)-1];
    logic [31:0] ref_rd = 32'h0;

    data_memory_ctrl #(.DEPTH_LOG2(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemUnsigned(MemUnsigned), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .MemBusy(MemBusy),
        .MemReady(MemReady), .MemError(MemError)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] w, v;
        w = ref_mem[(a / 4) % (1 << DEPTH)];
        case (sz)
            2'b00: begin
                v = (w >> (8 * (a % 4))) % 256;
                if (!u && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = (w >> (16 * ((a / 2) % 2))) % 65536;
                if (!u && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w, b;
        int n, idx, pos;
        idx = int'((a / 4) % (1 << DEPTH));
        w = ref_mem[idx];
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            pos = int'(a % 4) + k;
            b = (d >> (8 * k)) % 256;
            w = (w & ~(32'hFF << (8 * pos))) | (b << (8 * pos));
        end
        ref_mem[idx] = w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_op(input bit wr, input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        int cyc, busy;
        bit got;
        MemRead = !wr; MemWrite = wr; MemSize = sz; MemUnsigned = u;
        Address = a; WriteData = d;
        cyc = 0; busy = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (MemBusy) busy++;
            if (MemReady) got = 1'b1;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        if (wr) ref_store(a, sz, d);
        else    ref_rd = ref_load(a, sz, u);
        check({tag, " latency"}, 32'(cyc - 1), 32'(LAT + 1));
        check({tag, " busy_cycles"}, 32'(busy), 32'(LAT));
        check({tag, " rdata"}, ReadData, ref_rd);
        check({tag, " no_error"}, {31'd0, MemError}, 32'd0);
        @(posedge clk); #1;
        check({tag, " ready_pulse"}, {31'd0, MemReady}, 32'd0);
    endtask

    task automatic err_op(input bit rd, input bit wr, input logic [1:0] sz,
                          input logic [31:0] a, input string tag);
        MemRead = rd; MemWrite = wr; MemSize = sz; Address = a;
        WriteData = $urandom;
        @(posedge clk); #1;
        check({tag, " error"}, {31'd0, MemError}, 32'd1);
        check({tag, " busy"}, {31'd0, MemBusy}, 32'd0);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        check({tag, " error_pulse"}, {31'd0, MemError}, 32'd0);
        check({tag, " rdata"}, ReadData, ref_rd);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        repeat (2) @(posedge clk);
        #1;
        check("reset rdata", ReadData, 32'h0);
        check("reset busy", {31'd0, MemBusy}, 32'd0);
        check("reset ready", {31'd0, MemReady}, 32'd0);
        check("reset error", {31'd0, MemError}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle busy", {31'd0, MemBusy}, 32'd0);

        mem_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw10");
        mem_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw10");
        mem_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_007F, "sb12");
        mem_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "lb12");
        mem_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lb13");
        mem_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lbu13");
        mem_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, "lh10");
        mem_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw10b");

        err_op(1'b1, 1'b0, 2'b10, 32'h11, "lw_misaligned");
        err_op(1'b0, 1'b1, 2'b01, 32'h13, "sh_misaligned");
        err_op(1'b1, 1'b0, 2'b11, 32'h10, "size11");
        err_op(1'b1, 1'b1, 2'b10, 32'h10, "rd_and_wr");
        mem_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw10_after_err");

        // Held illegal request re-pulses every other cycle.
        MemRead = 1'b1; MemWrite = 1'b1; MemSize = 2'b10; Address = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("held_error", {31'd0, MemError}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        MemRead = 1'b0; MemWrite = 1'b0;

        // Reset during WAIT aborts the store.
        mem_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_2222, "sw20_prior");
        MemWrite = 1'b1; MemSize = 2'b10; Address = 32'h20; WriteData = 32'h1234_5678;
        @(posedge clk); #1;
        check("midrst busy_before", {31'd0, MemBusy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; MemWrite = 1'b0;
        ref_rd = 32'h0;
        check("midrst busy", {31'd0, MemBusy}, 32'd0);
        check("midrst rdata", ReadData, 32'h0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("midrst no_ready", {31'd0, MemReady}, 32'd0);
        mem_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw20_after_rst");

        mem_op(1'b1, 2'b10, 1'b0, 32'h1000, 32'hA5A5_A5A5, "sw_wrap");
        mem_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "lw_wrap");

        for (int i = 0; i < 16; i++) begin
            mem_op(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4 * i), $urandom, "init_win");
        end
        for (int i = 0; i < 60; i++) begin
            r  = int'($urandom_range(0, 9));
            sz = 2'($urandom_range(0, 2));
            a  = 32'h40 + 32'($urandom_range(0, 63));
            if (r == 9) begin
                err_op(1'b1, 1'b0, 2'b10, a | 32'h1, "rand_err");
            end else begin
                if (sz == 2'b01) a = a & ~32'h1;
                if (sz == 2'b10) a = a & ~32'h3;
                a = a | ($urandom << 12);
                mem_op(r < 4, sz, 1'($urandom_range(0, 1)), a, $urandom, "rand_op");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
